hazard_unit: RTL

//  Pipeline control for the 5-stage core. Drives the stall/flush inputs of the
//  IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. Covers load-use

---
 rtl/hazard_unit_if.sv | 50 +++++
 rtl/hazard_unit.sv | 102 ++++++++++
 2 files changed

// File: rtl/hazard_unit_if.sv
// rtl/hazard_unit_if.sv - pipeline hazard control bundle; stats ports under HAZARD_STATS_EN
interface hazard_unit_if #(
  parameter int REGW = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNTW = 32
`endif
);
  logic            ihit;
  logic            dhit;
  logic [REGW-1:0] ifid_rs;
  logic [REGW-1:0] ifid_rt;
  logic            idex_dmemREN;
  logic [REGW-1:0] idex_rt;
  logic            ex_pc_redirect;
  logic            exmem_dmemREN;
  logic            exmem_dmemWEN;
  logic            exmem_halt;
  logic            pc_en;
  logic            ifid_stall;
  logic            ifid_flush;
  logic            idex_stall;
  logic            idex_flush;
  logic            exmem_stall;
  logic            memwb_flush;
  logic            halted;
`ifdef HAZARD_STATS_EN
  logic [CNTW-1:0] stall_cycles;
  logic [CNTW-1:0] flush_count;
`endif

  modport master (
    output ihit, dhit, ifid_rs, ifid_rt, idex_dmemREN, idex_rt,
           ex_pc_redirect, exmem_dmemREN, exmem_dmemWEN, exmem_halt,
    input  pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush, halted
`ifdef HAZARD_STATS_EN
    , input stall_cycles, flush_count
`endif
  );

  modport slave (
    input  ihit, dhit, ifid_rs, ifid_rt, idex_dmemREN, idex_rt,
           ex_pc_redirect, exmem_dmemREN, exmem_dmemWEN, exmem_halt,
    output pc_en, ifid_stall, ifid_flush, idex_stall, idex_flush,
           exmem_stall, memwb_flush, halted
`ifdef HAZARD_STATS_EN
    , output stall_cycles, flush_count
`endif
  );
endinterface

// File: rtl/hazard_unit.sv
// rtl/hazard_unit.sv - 5-stage pipeline stall/flush control; HAZARD_STATS_EN adds stall/flush counters
module hazard_unit #(
  parameter int REGW = 5
`ifdef HAZARD_STATS_EN
  , parameter int CNTW = 32
`endif
) (
  input logic         CLK,
  input logic         nRST,
  hazard_unit_if.slave hif
);
  typedef enum logic [1:0] {RUN, LU_BUBBLE, MEM_WAIT, HALT} state_t;

  state_t state;
  state_t state_next;
  logic   memreq;
  logic   lu;
  logic   halt_ev;
  logic   mem_wait;
  logic   lu_ev;
  logic   redir_ev;
  logic   miss_ev;

  always_comb begin
    memreq   = hif.exmem_dmemREN | hif.exmem_dmemWEN;
    lu       = hif.idex_dmemREN && (hif.idex_rt != '0) &&
               ((hif.idex_rt == hif.ifid_rs) || (hif.idex_rt == hif.ifid_rt));
    halt_ev  = (state == HALT) || hif.exmem_halt;
    mem_wait = !halt_ev && ((state == RUN) || (state == MEM_WAIT)) && memreq && !hif.dhit;
    // A redirect squashes the dependent instruction, so it outranks the bubble.
    lu_ev    = !halt_ev && !mem_wait && (state != LU_BUBBLE) && lu && !hif.ex_pc_redirect;
    redir_ev = !halt_ev && !mem_wait && hif.ex_pc_redirect;
    miss_ev  = !halt_ev && !mem_wait && !lu_ev && !redir_ev && !hif.ihit;
  end

  always_comb begin
    hif.pc_en       = 1'b1;
    hif.ifid_stall  = 1'b0;
    hif.ifid_flush  = 1'b0;
    hif.idex_stall  = 1'b0;
    hif.idex_flush  = 1'b0;
    hif.exmem_stall = 1'b0;
    hif.memwb_flush = 1'b0;
    hif.halted      = halt_ev;
    state_next      = RUN;
    if (halt_ev) begin
      hif.pc_en       = 1'b0;
      hif.ifid_stall  = 1'b1;
      hif.idex_stall  = 1'b1;
      hif.exmem_stall = 1'b1;
      state_next      = HALT;
    end else if (mem_wait) begin
      hif.pc_en       = 1'b0;
      hif.ifid_stall  = 1'b1;
      hif.idex_stall  = 1'b1;
      hif.exmem_stall = 1'b1;
      hif.memwb_flush = 1'b1;
      state_next      = MEM_WAIT;
    end else if (lu_ev) begin
      hif.pc_en       = 1'b0;
      hif.ifid_stall  = 1'b1;
      hif.idex_flush  = 1'b1;
      state_next      = LU_BUBBLE;
    end else if (redir_ev) begin
      hif.ifid_flush  = 1'b1;
      hif.idex_flush  = 1'b1;
    end else if (miss_ev) begin
      hif.pc_en       = 1'b0;
      hif.ifid_flush  = 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [CNTW-1:0] stall_q;
  logic [CNTW-1:0] flush_q;

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!hif.pc_en && (state != HALT) && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (redir_ev && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end

  assign hif.stall_cycles = stall_q;
  assign hif.flush_count  = flush_q;
`endif
endmodule
